// File: rtl/clock_pkg.sv
// Shared constants, BCD digit-pair type and hour-to-display conversion for the
// wall-clock time-of-day core.
package clock_pkg;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

    // Binary hour 0..23 to a BCD digit pair; 12 h mode shows 0 as 12 and 13..23 as 1..11.
    function automatic bcd_pair_t hour_to_bcd(input logic [4:0] hour, input logic mode_12h);
        logic [4:0] h;
        bcd_pair_t  r;
        h = hour;
        if (mode_12h) begin
            if (hour == 5'd0) begin
                h = 5'd12;
            end else if (hour > 5'd12) begin
                h = hour - 5'd12;
            end
        end
        if (h >= 5'd20) begin
            r.tens  = 4'd2;
            r.units = 4'(h - 5'd20);
        end else if (h >= 5'd10) begin
            r.tens  = 4'd1;
            r.units = 4'(h - 5'd10);
        end else begin
            r.tens  = 4'd0;
            r.units = h[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_time_counter_if.sv
// Control/display bundle between the time-of-day core and its surroundings
// (debounced buttons, alarm settings, seven-segment digits).
interface bcd_time_counter_if #(
    parameter int unsigned SEC_W = 6
);
    logic             run;
    logic             inc_min;
    logic             inc_hour;
    logic             mode_12h;
    logic             alarm_on;
    logic [7:0]       alarm_hh;
    logic [7:0]       alarm_mm;
    logic             alarm_ack;
    logic [3:0]       hours2;
    logic [3:0]       hours1;
    logic [3:0]       mins2;
    logic [3:0]       mins1;
    logic [SEC_W-1:0] secs;
    logic             pm;
    logic             sec_tick;
    logic             alarm;

    modport master (
        output run, inc_min, inc_hour, mode_12h, alarm_on, alarm_hh, alarm_mm, alarm_ack,
        input  hours2, hours1, mins2, mins1, secs, pm, sec_tick, alarm
    );

    modport slave (
        input  run, inc_min, inc_hour, mode_12h, alarm_on, alarm_hh, alarm_mm, alarm_ack,
        output hours2, hours1, mins2, mins1, secs, pm, sec_tick, alarm
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides the input clock by CLK_HZ; tick is high for the single enabled cycle
// in which the count wraps. The count holds while en is low.
module tick_prescaler #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);
    localparam int unsigned    CntW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day core: 1 Hz prescaler, binary seconds, BCD minutes, binary hours
// with 24 h / 12 h BCD display, set pulses and a latched HH:MM alarm.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SEC_W    = 6,
    parameter bit          ALARM_EN = 1'b1
) (
    input  logic               CLK100MHZ,
    input  logic               reset_n,
    bcd_time_counter_if.slave  bus
);
    logic       tick;
    logic [5:0] sec_q, sec_d;
    bcd_pair_t  min_q, min_d;
    logic [4:0] hour_q, hour_d;
    bcd_pair_t  hdisp_q, hdisp_d;
    logic       pm_q, pm_d;
    logic       sec_tick_q;
    logic       alarm_q, alarm_d;

    logic       min_carry, min_step, hour_step, min_at_max;
    logic       al_valid, alarm_hit;
    logic [4:0] al_hour;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk     (CLK100MHZ),
        .reset_n (reset_n),
        .en      (bus.run),
        .tick    (tick)
    );

    always_comb begin
        min_at_max = (min_q.tens == 4'(MIN_MAX / 10)) && (min_q.units == 4'(MIN_MAX % 10));
        min_carry  = tick && (sec_q == 6'(SEC_MAX));
        // A set pulse coinciding with a carry still advances the field by exactly one.
        min_step   = min_carry || bus.inc_min;
        hour_step  = (min_carry && min_at_max) || bus.inc_hour;

        sec_d = sec_q;
        if (tick) begin
            sec_d = min_carry ? 6'd0 : sec_q + 6'd1;
        end

        min_d = min_q;
        if (min_step) begin
            if (min_q.units == 4'd9) begin
                min_d.units = 4'd0;
                min_d.tens  = min_at_max ? 4'd0 : min_q.tens + 4'd1;
            end else begin
                min_d.units = min_q.units + 4'd1;
            end
        end

        hour_d = hour_q;
        if (hour_step) begin
            hour_d = (hour_q == 5'(HOUR_MAX)) ? 5'd0 : hour_q + 5'd1;
        end

        hdisp_d = hour_to_bcd(hour_d, bus.mode_12h);
        pm_d    = (hour_d >= 5'd12);
    end

    // Alarm compare against the time being loaded this cycle, so it rises with the digits.
    always_comb begin
        al_valid  = (bus.alarm_hh[7:4] <= 4'd2) && (bus.alarm_hh[3:0] <= 4'd9) &&
                    (bus.alarm_mm[7:4] <= 4'd5) && (bus.alarm_mm[3:0] <= 4'd9);
        al_hour   = 5'(bus.alarm_hh[7:4]) * 5'd10 + 5'(bus.alarm_hh[3:0]);
        al_valid  = al_valid && (al_hour <= 5'(HOUR_MAX));
        alarm_hit = ALARM_EN && bus.alarm_on && al_valid &&
                    (min_carry || bus.inc_min || bus.inc_hour) &&
                    (hour_d == al_hour) &&
                    (min_d.tens == bus.alarm_mm[7:4]) && (min_d.units == bus.alarm_mm[3:0]);

        alarm_d = alarm_q;
        if (!(ALARM_EN && bus.alarm_on)) begin
            alarm_d = 1'b0;
        end else if (alarm_hit) begin
            alarm_d = 1'b1;
        end else if (bus.alarm_ack) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            hdisp_q    <= '0;
            pm_q       <= 1'b0;
            sec_tick_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            hdisp_q    <= hdisp_d;
            pm_q       <= pm_d;
            sec_tick_q <= tick;
            alarm_q    <= alarm_d;
        end
    end

    assign bus.hours2   = hdisp_q.tens;
    assign bus.hours1   = hdisp_q.units;
    assign bus.mins2    = min_q.tens;
    assign bus.mins1    = min_q.units;
    assign bus.secs     = SEC_W'(sec_q);
    assign bus.pm       = pm_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.alarm    = alarm_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with a 4-cycle second; expected values are
// hand-computed from the stimulus sequence.
module tb_bcd_time_counter;
    localparam int unsigned CLK_HZ = 4;
    localparam int unsigned SEC_W  = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [15:0] hhmm;

    bcd_time_counter_if #(.SEC_W(SEC_W)) bus ();

    bcd_time_counter #(
        .CLK_HZ   (CLK_HZ),
        .SEC_W    (SEC_W),
        .ALARM_EN (1'b1)
    ) dut (
        .CLK100MHZ (clk),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    assign hhmm = {bus.hours2, bus.hours1, bus.mins2, bus.mins1};

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin
            bus.inc_min = 1'b1;
            @(negedge clk);
            bus.inc_min = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_hour(input int n);
        repeat (n) begin
            bus.inc_hour = 1'b1;
            @(negedge clk);
            bus.inc_hour = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.run = 1'b1;
        step(2);
        n_checks++;
        if (hhmm !== 16'h0000) $display("FAIL reset_digits: got %h expected 0000", hhmm);
        else n_pass++;
        n_checks++;
        if ({bus.secs, bus.pm, bus.sec_tick, bus.alarm} !== '0)
            $display("FAIL reset_flags: secs=%0d pm=%b tick=%b alarm=%b expected all 0",
                     bus.secs, bus.pm, bus.sec_tick, bus.alarm);
        else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_sec_wrap;
        int ticks, bad_gap, last_tick;
        ticks = 0; bad_gap = 0; last_tick = 0;
        for (int c = 1; c <= 240; c++) begin
            @(negedge clk);
            if (bus.sec_tick === 1'b1) begin
                ticks++;
                if (last_tick + 4 != c) bad_gap++;
                last_tick = c;
            end
            if (c == 236) begin
                n_checks++;
                if (bus.secs !== 6'd59) $display("FAIL secs_at_59: got %0d expected 59", bus.secs);
                else n_pass++;
            end
        end
        bus.run = 1'b0;
        n_checks++;
        if (ticks != 60) $display("FAIL tick_count: got %0d expected 60", ticks);
        else n_pass++;
        n_checks++;
        if (bad_gap != 0) $display("FAIL tick_spacing: got %0d bad gaps expected 0", bad_gap);
        else n_pass++;
        n_checks++;
        if (bus.secs !== 6'd0) $display("FAIL sec_wrap: got %0d expected 0", bus.secs);
        else n_pass++;
        n_checks++;
        if (hhmm !== 16'h0001) $display("FAIL min_carry: got %h expected 0001", hhmm);
        else n_pass++;
    endtask

    task automatic test_midnight;
        pulse_hour(23);
        pulse_min(58);
        n_checks++;
        if ({hhmm, bus.pm} !== {16'h2359, 1'b1})
            $display("FAIL preset_2359: got %h pm=%b expected 2359 pm=1", hhmm, bus.pm);
        else n_pass++;
        bus.run = 1'b1;
        step(236);
        n_checks++;
        if (bus.secs !== 6'd59) $display("FAIL preset_secs: got %0d expected 59", bus.secs);
        else n_pass++;
        step(4);
        bus.run = 1'b0;
        n_checks++;
        if ({hhmm, bus.secs, bus.pm} !== {16'h0000, 6'd0, 1'b0})
            $display("FAIL midnight: got %h:%0d pm=%b expected 0000:0 pm=0",
                     hhmm, bus.secs, bus.pm);
        else n_pass++;
    endtask

    task automatic test_simul_carry;
        pulse_hour(10);
        pulse_min(15);
        bus.run = 1'b1;
        step(239);
        bus.inc_min = 1'b1;
        step(1);
        bus.inc_min = 1'b0;
        bus.run = 1'b0;
        n_checks++;
        if ({hhmm, bus.secs} !== {16'h1016, 6'd0})
            $display("FAIL carry_plus_inc: got %h:%0d expected 1016:0", hhmm, bus.secs);
        else n_pass++;
    endtask

    task automatic test_min_wrap;
        pulse_min(43);
        n_checks++;
        if (hhmm !== 16'h1059) $display("FAIL min_to_59: got %h expected 1059", hhmm);
        else n_pass++;
        pulse_min(1);
        n_checks++;
        if ({hhmm, bus.secs} !== {16'h1000, 6'd0})
            $display("FAIL min_wrap_no_hour: got %h:%0d expected 1000:0", hhmm, bus.secs);
        else n_pass++;
    endtask

    task automatic test_12h;
        int         incs [5] = '{14, 11, 1, 1, 10};
        logic [7:0] disp [5] = '{8'h12, 8'h11, 8'h12, 8'h01, 8'h11};
        logic       pm_e [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus.mode_12h = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) begin
            pulse_hour(incs[i]);
            n_checks++;
            if ({hhmm[15:8], bus.pm} !== {disp[i], pm_e[i]})
                $display("FAIL h12_%0d: got %h pm=%b expected %h pm=%b",
                         i, hhmm[15:8], bus.pm, disp[i], pm_e[i]);
            else n_pass++;
        end
        bus.mode_12h = 1'b0;
        step(1);
        n_checks++;
        if (hhmm !== 16'h2300) $display("FAIL h24_restore: got %h expected 2300", hhmm);
        else n_pass++;
        pulse_hour(1);
        n_checks++;
        if (hhmm !== 16'h0000) $display("FAIL hour_wrap: got %h expected 0000", hhmm);
        else n_pass++;
    endtask

    task automatic test_alarm;
        int early, fired;
        early = 0; fired = 0;
        bus.alarm_hh = 8'h07;
        bus.alarm_mm = 8'h30;
        bus.alarm_on = 1'b1;
        pulse_hour(7);
        pulse_min(29);
        n_checks++;
        if ({hhmm, bus.alarm} !== {16'h0729, 1'b0})
            $display("FAIL alarm_pre: got %h alarm=%b expected 0729 alarm=0", hhmm, bus.alarm);
        else n_pass++;
        bus.run = 1'b1;
        for (int c = 1; c <= 240; c++) begin
            @(negedge clk);
            if (c < 240 && bus.alarm !== 1'b0) early++;
        end
        bus.run = 1'b0;
        n_checks++;
        if (early != 0) $display("FAIL alarm_early: got %0d cycles expected 0", early);
        else n_pass++;
        n_checks++;
        if ({hhmm, bus.alarm} !== {16'h0730, 1'b1})
            $display("FAIL alarm_rise: got %h alarm=%b expected 0730 alarm=1", hhmm, bus.alarm);
        else n_pass++;
        bus.alarm_ack = 1'b1;
        step(1);
        bus.alarm_ack = 1'b0;
        step(2);
        n_checks++;
        if (bus.alarm !== 1'b0) $display("FAIL alarm_ack: got %b expected 0", bus.alarm);
        else n_pass++;
        bus.alarm_mm = 8'h3A;
        repeat (59) begin
            pulse_min(1);
            if (bus.alarm !== 1'b0) fired++;
        end
        n_checks++;
        if (fired != 0) $display("FAIL alarm_non_bcd: got %0d fires expected 0", fired);
        else n_pass++;
        bus.alarm_mm = 8'h30;
        pulse_min(1);
        n_checks++;
        if ({hhmm, bus.alarm} !== {16'h0730, 1'b1})
            $display("FAIL alarm_by_inc: got %h alarm=%b expected 0730 alarm=1", hhmm, bus.alarm);
        else n_pass++;
        bus.alarm_on = 1'b0;
        step(1);
        n_checks++;
        if (bus.alarm !== 1'b0) $display("FAIL alarm_disarm: got %b expected 0", bus.alarm);
        else n_pass++;
        bus.alarm_on  = 1'b1;
        bus.alarm_mm  = 8'h31;
        bus.alarm_ack = 1'b1;
        bus.inc_min   = 1'b1;
        step(1);
        bus.alarm_ack = 1'b0;
        bus.inc_min   = 1'b0;
        n_checks++;
        if (bus.alarm !== 1'b1) $display("FAIL set_beats_ack: got %b expected 1", bus.alarm);
        else n_pass++;
        bus.alarm_on = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid;
        int first;
        first = 0;
        pulse_hour(5);
        pulse_min(3);
        bus.run = 1'b1;
        step(226);
        n_checks++;
        if ({hhmm, bus.secs, bus.pm} !== {16'h1234, 6'd56, 1'b1})
            $display("FAIL preset_123456: got %h:%0d pm=%b expected 1234:56 pm=1",
                     hhmm, bus.secs, bus.pm);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({hhmm, bus.secs, bus.pm, bus.sec_tick, bus.alarm} !== '0)
            $display("FAIL async_reset: got %h:%0d pm=%b tick=%b alarm=%b expected all 0",
                     hhmm, bus.secs, bus.pm, bus.sec_tick, bus.alarm);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.sec_tick === 1'b1 && first == 0) first = c;
        end
        n_checks++;
        if (first != 4) $display("FAIL first_tick_after_reset: got cycle %0d expected 4", first);
        else n_pass++;
        n_checks++;
        if (bus.secs !== 6'd2) $display("FAIL secs_after_reset: got %0d expected 2", bus.secs);
        else n_pass++;
    endtask

    initial begin
        bus.run       = 1'b0;
        bus.inc_min   = 1'b0;
        bus.inc_hour  = 1'b0;
        bus.mode_12h  = 1'b0;
        bus.alarm_on  = 1'b0;
        bus.alarm_hh  = 8'h00;
        bus.alarm_mm  = 8'h00;
        bus.alarm_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_sec_wrap();
        test_midnight();
        test_simul_carry();
        test_min_wrap();
        test_12h();
        test_alarm();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end
endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Parametrised time-of-day core for the wall-clock top level. It divides the board clock to a 1 Hz tick and keeps seconds, minutes and hours, with minutes and hours presented as BCD digit pairs for the seven-segment driver. It accepts pre-debounced minute/hour set pulses, switches between 24 h and 12 h display at run time, and raises a latched alarm on a programmable HH:MM match. It sits between the debounce blocks and the seven-segment driver, replacing the inline counter logic in the top level.

## Interface
- CLK_HZ, 100_000_000: input clock frequency; the prescaler divides by exactly this value.
- SEC_W, 6: width of the binary seconds output (minimum 6).
- ALARM_EN, 1: 1 builds the alarm comparator; 0 ties `alarm` low and ignores the alarm inputs.

- CLK100MHZ  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  1 = time advances; 0 = prescaler and seconds frozen (set pulses still act)
- inc_min  in  1  single-cycle pulse, already debounced
- inc_hour  in  1  single-cycle pulse, already debounced
- mode_12h  in  1  0 = 24 h display, 1 = 12 h display
- alarm_on  in  1  alarm arm
- alarm_hh  in  8  alarm hour, BCD, 24 h (00–23)
- alarm_mm  in  8  alarm minute, BCD (00–59)
- alarm_ack  in  1  pulse; clears a latched alarm
- hours2, hours1, mins2, mins1  out  4 each  BCD display digits (tens, units)
- secs  out  SEC_W  binary seconds 0–59, for the LED bar
- pm  out  1  1 when internal hour ≥ 12 (valid in both modes)
- sec_tick  out  1  one-cycle pulse on every seconds update
- alarm  out  1  latched alarm flag

## Operation
- Internal state: prescaler 0..CLK_HZ-1, sec 0..59 (binary), min as BCD tens/units, hour 0..23 (binary).
- Prescaler increments while `run`=1 and wraps at CLK_HZ-1. The wrap cycle is the tick.
- On a tick, sec increments. At 59→0, a minute carry is generated. A minute carry at 59→00 generates an hour carry; the hour wraps 23→0.
- `inc_min` advances the minute by 1, wrapping 59→00 with no hour carry and no effect on seconds. `inc_hour` advances the hour by 1, wrapping 23→0.
- Simultaneous events: if a set pulse and a carry hit the same field in the same cycle, that field advances by exactly 1. `inc_min` and `inc_hour` together advance both fields.
- Display: 24 h mode shows the hour in BCD, 00–23. 12 h mode maps 0→12, 1–11→1–11, 12→12, 13–23→1–11; `hours2` is 0 or 1 and no leading-zero suppression is applied. `mode_12h` affects the display only, never the stored state.
- Alarm: sets when `alarm_on`=1 and a minute carry or `inc_min`/`inc_hour` produces {hour, min} equal to {alarm_hh, alarm_mm}. It stays set until `alarm_ack`, or until `alarm_on`=0. Non-BCD or out-of-range alarm values never match.
- If `alarm_ack` and a set condition occur in the same cycle, set wins.
- Reset values: all counters 0, all digits 0, secs=0, pm=0, sec_tick=0, alarm=0. Reset asserted mid-second discards the partial prescaler count.

## Timing
- All outputs are registered. A state change caused at edge k is visible after edge k.
- `sec_tick` is high in the same cycle that `secs` shows the new value. Period is exactly CLK_HZ cycles while `run`=1.
- A set pulse sampled at edge k updates the digits after edge k (1-cycle latency).
- `alarm` rises at the edge that loads the matching time: the same cycle the minute digits change.
- Deasserting `run` holds the prescaler count. Reasserting it resumes from that count, with no extra tick.
- Reset assertion clears outputs asynchronously. Deassertion is synchronised by the top level; this block needs no internal reset synchroniser.

## Structure
- Shared package `clock_pkg` holds: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, a BCD digit-pair type, and a function for binary hour (0–23) to BCD with 12 h mapping.
- Sub-module `tick_prescaler` (params CLK_HZ; ports clk, reset_n, en, tick) is instantiated once. It is reusable for the debouncer sample clock.
- Estimated size: ~200–300 lines including the package.

## Test plan
- CLK_HZ=4, run=1, 60·4 cycles after reset → secs 59→0 wrap, mins1=1, sec_tick count=60, each pulse exactly 4 cycles apart.
- Preset 23:59:59 via set pulses and ticks, then one tick → 00:00:00, pm 1→0.
- Pulse inc_min in the same cycle as the 59→0 seconds carry at 10:15 → 10:16, not 10:17. Pulse inc_min at xx:59 → xx:00 with the hour unchanged.
- mode_12h=1 at hours 0, 11, 12, 13, 23 → digits 12, 11, 12, 01, 11; pm = 0, 0, 1, 1, 1.
- alarm_hh=8'h07, alarm_mm=8'h30, alarm_on=1, time reaches 07:30 → alarm high in the same cycle mins1=0. alarm_ack → low. alarm_mm=8'h3A → never fires.
- Assert reset_n=0 mid-second at 12:34:56 → all outputs 0 immediately. Release → the first tick arrives CLK_HZ cycles later.
